// File: rtl/pipe_mult_if.sv
// Request/response bundle for the pipelined multiplier: issue controls, operands, tag and
// completion outputs. Clock and reset stay as plain ports on the multiplier.
interface pipe_mult_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 6
);
    logic             start;
    logic             nuke;
    logic             stall;
    logic [1:0]       func;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [TAG_W-1:0] tag_in;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag_out;
    logic             busy;

    modport master (
        output start, nuke, stall, func, mcand, mplier, tag_in,
        input  done, result, tag_out, busy
    );

    modport slave (
        input  start, nuke, stall, func, mcand, mplier, tag_in,
        output done, result, tag_out, busy
    );
endinterface

// File: rtl/pipe_mult.sv
// STAGES-deep shift-and-add multiplier, one multiplier chunk per stage, one op per cycle.
// Define PIPE_MULT_HIGH_EN for MULH/MULHSU/MULHU support on a 2*WIDTH datapath.
module pipe_mult #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 8,
    parameter int unsigned TAG_W  = 6
) (
    input logic       clock,
    input logic       reset,
    pipe_mult_if.slave bus
);

`ifdef PIPE_MULT_HIGH_EN
    localparam int unsigned DW = 2 * WIDTH;
`else
    localparam int unsigned DW = WIDTH;
`endif
    localparam int unsigned CHUNK = DW / STAGES;

    logic [STAGES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q    [STAGES];
    logic [DW-1:0]     prod_q   [STAGES];
    logic [DW-1:0]     mcand_q  [STAGES];
    logic [DW-1:0]     mplier_q [STAGES];

    logic [DW-1:0]     prod_d   [STAGES];
    logic [DW-1:0]     mcand_d  [STAGES];
    logic [DW-1:0]     mplier_d [STAGES];
    logic [DW-1:0]     in_prod  [STAGES];
    logic [DW-1:0]     in_mcand [STAGES];
    logic [DW-1:0]     in_mplier[STAGES];

    logic [DW-1:0]     mcand_ext;
    logic [DW-1:0]     mplier_ext;

`ifdef PIPE_MULT_HIGH_EN
    logic [1:0] func_q [STAGES];
    logic       mcand_sgn;
    logic       mplier_sgn;

    always_comb begin
        mcand_sgn  = ((bus.func == 2'd1) || (bus.func == 2'd2)) && bus.mcand[WIDTH-1];
        mplier_sgn = (bus.func == 2'd1) && bus.mplier[WIDTH-1];
        mcand_ext  = {{WIDTH{mcand_sgn}}, bus.mcand};
        mplier_ext = {{WIDTH{mplier_sgn}}, bus.mplier};
    end
`else
    logic unused_func;
    assign unused_func = ^bus.func;
    assign mcand_ext   = bus.mcand;
    assign mplier_ext  = bus.mplier;
`endif

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign in_prod[s]   = '0;
            assign in_mcand[s]  = mcand_ext;
            assign in_mplier[s] = mplier_ext;
        end else begin : g_rest
            assign in_prod[s]   = prod_q[s-1];
            assign in_mcand[s]  = mcand_q[s-1];
            assign in_mplier[s] = mplier_q[s-1];
        end
        // Product wraps modulo 2^DW, which is what makes sign-extended operands work.
        assign prod_d[s]   = in_prod[s] + DW'(in_mplier[s][CHUNK-1:0]) * in_mcand[s];
        assign mplier_d[s] = in_mplier[s] >> CHUNK;
        assign mcand_d[s]  = in_mcand[s] << CHUNK;
    end

    // Valid bits: reset beats nuke beats stall.
    always_ff @(posedge clock) begin
        if (reset || bus.nuke) begin
            valid_q <= '0;
        end else if (!bus.stall) begin
            valid_q[0] <= bus.start;
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!bus.stall) begin
            tag_q[0] <= bus.tag_in;
`ifdef PIPE_MULT_HIGH_EN
            func_q[0] <= bus.func;
`endif
            for (int s = 0; s < STAGES; s++) begin
                prod_q[s]   <= prod_d[s];
                mcand_q[s]  <= mcand_d[s];
                mplier_q[s] <= mplier_d[s];
            end
            for (int s = 1; s < STAGES; s++) begin
                tag_q[s] <= tag_q[s-1];
`ifdef PIPE_MULT_HIGH_EN
                func_q[s] <= func_q[s-1];
`endif
            end
        end
    end

    logic unused_tail;
    assign unused_tail = ^{mcand_q[STAGES-1], mplier_q[STAGES-1]};

    assign bus.done    = valid_q[STAGES-1];
    assign bus.busy    = |valid_q;
    assign bus.tag_out = tag_q[STAGES-1];
`ifdef PIPE_MULT_HIGH_EN
    assign bus.result  = (func_q[STAGES-1] == 2'd0) ? prod_q[STAGES-1][WIDTH-1:0]
                                                    : prod_q[STAGES-1][DW-1:WIDTH];
`else
    assign bus.result  = prod_q[STAGES-1];
`endif

endmodule

// File: doc/pipe_mult.md
PIPE_MULT -- requirements
Module: pipe_mult

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits.
REQ-002 Parameter STAGES, default 8, pipeline depth; 2*WIDTH SHALL be divisible by STAGES.
REQ-003 Parameter TAG_W, default 6, width of the sideband tag carried with each operation.
REQ-004 clock  input  1  clock; all state changes on posedge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  issue request; operands sampled when start=1 and stall=0.
REQ-007 nuke  input  1  flush; kills every in-flight operation.
REQ-008 stall  input  1  freeze; holds all stages and ignores start.
REQ-009 func  input  2  operation: 0=MUL low, 1=MULH signed*signed high, 2=MULHSU signed*unsigned high, 3=MULHU unsigned high.
REQ-010 mcand  input  WIDTH  multiplicand.
REQ-011 mplier  input  WIDTH  multiplier.
REQ-012 tag_in  input  TAG_W  sideband tag.
REQ-013 done  output  1  result valid this cycle.
REQ-014 result  output  WIDTH  selected half of product.
REQ-015 tag_out  output  TAG_W  tag of the completing operation.
REQ-016 busy  output  1  OR of all stage valid bits.

Function
REQ-017 Operands SHALL be extended to 2*WIDTH per func: mcand sign-extended for func 1 and 2; mplier sign-extended for func 1 only; all others zero-extended.
REQ-018 Each stage SHALL consume 2*WIDTH/STAGES multiplier bits: it adds chunk*mcand to the running product, shifts mplier right by the chunk width, and shifts mcand left by the chunk width; all arithmetic is modulo 2^(2*WIDTH).
REQ-019 Each stage SHALL carry a valid bit, func and tag alongside its data.
REQ-020 Latency SHALL be exactly STAGES cycles from an accepted start to done=1 when stall is low throughout.
REQ-021 Throughput SHALL be one operation per cycle; back-to-back starts SHALL complete on consecutive cycles in issue order.
REQ-022 result SHALL be product[WIDTH-1:0] for func 0 and product[2*WIDTH-1:WIDTH] for func 1-3.
REQ-023 While stall=1, every stage register, done, result and tag_out SHALL hold; each cycle of stall extends latency by one.
REQ-024 nuke=1 SHALL clear all valid bits and done on the next edge, including any start in the same cycle.
REQ-025 nuke=1 SHALL take priority over stall.
REQ-026 Data registers need not be cleared by nuke or reset; only valid bits, done and busy are controlled.
REQ-027 done SHALL be 1 for exactly one unstalled cycle per operation.
REQ-028 result and tag_out are don't-care when done=0.

Reset
REQ-029 reset=1 SHALL clear all stage valid bits, so done=0 and busy=0 on the following cycle.
REQ-030 reset SHALL override start, stall and nuke.
REQ-031 An operation in flight at reset SHALL never assert done.

Configuration
REQ-032 Macro PIPE_MULT_HIGH_EN defined: func is honoured as in REQ-017 and REQ-022, with a 2*WIDTH internal datapath.
REQ-033 PIPE_MULT_HIGH_EN undefined:
- func is ignored;
- operands are zero-extended;
- internal datapath is WIDTH bits;
- STAGES SHALL divide WIDTH, and each stage consumes WIDTH/STAGES bits;
- result = low WIDTH bits of the product.

Verification
REQ-034 Use WIDTH=64, STAGES=8. Stimulus: func=0, mcand=3, mplier=5, tag=0x2A, single start. Response: done exactly 8 cycles later, result=15, tag_out=0x2A.
REQ-035 Stimulus: func=1, mcand=-1, mplier=-1. Response: result=0. Stimulus: func=3, same operands. Response: result=0xFFFFFFFFFFFFFFFE. Stimulus: func=2, mcand=-1, mplier=2. Response: result=0xFFFFFFFFFFFFFFFF.
REQ-036 Stimulus: 8 back-to-back starts with mplier=i, mcand=7. Response: 8 consecutive done cycles, results 0,7,...,49 in order, busy=1 throughout.
REQ-037 Stimulus: start, then stall high for 3 cycles at cycle 4. Response: done at cycle 11; outputs stable during the stall.
REQ-038 Stimulus: 4 in-flight operations, then nuke together with start. Response: no done ever for those operations, busy=0 next cycle; a start issued after the nuke completes normally.
REQ-039 Stimulus: reset asserted mid-stream. Response: done=0 and busy=0 from the next cycle; no stale completions.
